// File: rtl/fmrv32im_div_pkg.sv
// Shared types and constants for the divide/remainder issue controller.
//   div_op_t   : RV32IM divide-class operation, encoding matches REQ_OP
//   state_t    : controller sequencing states
//   DIV_ZERO_Q : quotient returned for a zero divisor
//   INT_MIN    : most negative 32-bit signed value
package fmrv32im_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CAP   = 3'd3,
        S_RESP  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/fmrv32im_div_fast.sv
// Combinational detector for divide cases with an architecturally fixed
// result, so they never need the multi-cycle divider.
//   op   in  : requested operation
//   rs1  in  : dividend
//   rs2  in  : divisor
//   hit  out : request resolves locally
//   data out : local result, valid when hit=1
module fmrv32im_div_fast
    import fmrv32im_div_pkg::*;
(
    input  div_op_t     op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        hit,
    output logic [31:0] data
);

    logic ovf;

    // Signed overflow only exists for INT_MIN / -1.
    assign ovf = (rs1 == INT_MIN) && (rs2 == '1);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        if (rs2 == '0) begin
            hit  = 1'b1;
            data = ((op == DIV) || (op == DIVU)) ? DIV_ZERO_Q : rs1;
        end else if (ovf && (op == DIV)) begin
            hit  = 1'b1;
            data = INT_MIN;
        end else if (ovf && (op == REM)) begin
            hit  = 1'b1;
            data = '0;
        end
    end

endmodule

// File: rtl/fmrv32im_div_ctrl.sv
// Issue/return sequencer between the execute stage and the multi-cycle
// divider. Resolves special cases locally, serves repeats from a one-entry
// result cache, otherwise pulses the divider and returns its result.
//   REQ_*      : request handshake, op, operands and destination index
//   FLUSH      : discard in-flight request and any pending result
//   DIV_INST_* : one-cycle start pulses; DIV_RS1/DIV_RS2 operands
//   DIV_WAIT/DIV_READY/DIV_RD : divider status and result
//   RES_*      : result handshake, data and destination index
module fmrv32im_div_ctrl
    import fmrv32im_div_pkg::*;
#(
    parameter int unsigned FAST_EN  = 1,
    parameter int unsigned CACHE_EN = 1
) (
    input  logic        RST_N,
    input  logic        CLK,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [1:0]  REQ_OP,
    input  logic [31:0] REQ_RS1,
    input  logic [31:0] REQ_RS2,
    input  logic [4:0]  REQ_RD,
    input  logic        FLUSH,
    output logic        DIV_INST_DIV,
    output logic        DIV_INST_DIVU,
    output logic        DIV_INST_REM,
    output logic        DIV_INST_REMU,
    output logic [31:0] DIV_RS1,
    output logic [31:0] DIV_RS2,
    input  logic        DIV_WAIT,
    input  logic        DIV_READY,
    input  logic [31:0] DIV_RD,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic [31:0] RES_DATA,
    output logic [4:0]  RES_RD
);

    state_t      state_q, state_d;
    logic        drain_rdy_q, drain_rdy_d;
    div_op_t     op_q, op_d;
    logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] res_data_q, res_data_d;
    logic        cache_vld_q, cache_vld_d;
    div_op_t     cache_op_q, cache_op_d;
    logic [31:0] cache_rs1_q, cache_rs1_d, cache_rs2_q, cache_rs2_d;
    logic [31:0] cache_data_q, cache_data_d;

    div_op_t     req_op;
    logic        fast_hit_raw, fast_hit, cache_hit, accept, pulse;
    logic [31:0] fast_data;

    assign req_op = div_op_t'(REQ_OP);

    fmrv32im_div_fast u_fast (
        .op   (req_op),
        .rs1  (REQ_RS1),
        .rs2  (REQ_RS2),
        .hit  (fast_hit_raw),
        .data (fast_data)
    );

    assign fast_hit  = (FAST_EN != 0) && fast_hit_raw;
    assign cache_hit = (CACHE_EN != 0) && cache_vld_q && (cache_op_q == req_op)
                       && (cache_rs1_q == REQ_RS1) && (cache_rs2_q == REQ_RS2);
    assign accept    = REQ_VALID && (state_q == S_IDLE) && !FLUSH;
    assign pulse     = (state_q == S_ISSUE) && !DIV_WAIT;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            drain_rdy_q  <= 1'b0;
            op_q         <= DIV;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            res_data_q   <= '0;
            cache_vld_q  <= 1'b0;
            cache_op_q   <= DIV;
            cache_rs1_q  <= '0;
            cache_rs2_q  <= '0;
            cache_data_q <= '0;
        end else begin
            state_q      <= state_d;
            drain_rdy_q  <= drain_rdy_d;
            op_q         <= op_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            res_data_q   <= res_data_d;
            cache_vld_q  <= cache_vld_d;
            cache_op_q   <= cache_op_d;
            cache_rs1_q  <= cache_rs1_d;
            cache_rs2_q  <= cache_rs2_d;
            cache_data_q <= cache_data_d;
        end
    end

    // drain_rdy marks that DIV_READY has been seen; the following cycle
    // carries the discarded DIV_RD, after which the divider is idle again.
    always_comb begin
        state_d     = state_q;
        drain_rdy_d = 1'b0;
        case (state_q)
            S_IDLE:
                if (accept) state_d = (fast_hit || cache_hit) ? S_RESP : S_ISSUE;
            S_ISSUE:
                if (FLUSH)      state_d = pulse ? S_DRAIN : S_IDLE;
                else if (pulse) state_d = S_WAIT;
            S_WAIT:
                if (FLUSH) begin
                    state_d     = S_DRAIN;
                    drain_rdy_d = DIV_READY;
                end else if (DIV_READY) begin
                    state_d = S_CAP;
                end
            S_CAP:
                if (FLUSH) begin
                    state_d     = S_DRAIN;
                    drain_rdy_d = 1'b1;
                end else begin
                    state_d = S_RESP;
                end
            S_RESP:
                if (FLUSH || RES_READY) state_d = S_IDLE;
            S_DRAIN:
                if (drain_rdy_q) state_d = S_IDLE;
                else             drain_rdy_d = DIV_READY;
            default:
                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d         = op_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        res_data_d   = res_data_q;
        cache_vld_d  = cache_vld_q;
        cache_op_d   = cache_op_q;
        cache_rs1_d  = cache_rs1_q;
        cache_rs2_d  = cache_rs2_q;
        cache_data_d = cache_data_q;
        if (accept) begin
            op_d  = req_op;
            rs1_d = REQ_RS1;
            rs2_d = REQ_RS2;
            rd_d  = REQ_RD;
            if (fast_hit)       res_data_d = fast_data;
            else if (cache_hit) res_data_d = cache_data_q;
        end
        if ((state_q == S_CAP) && !FLUSH) begin
            res_data_d   = DIV_RD;
            cache_vld_d  = 1'b1;
            cache_op_d   = op_q;
            cache_rs1_d  = rs1_q;
            cache_rs2_d  = rs2_q;
            cache_data_d = DIV_RD;
        end
    end

    always_comb begin
        REQ_READY     = (state_q == S_IDLE);
        RES_VALID     = (state_q == S_RESP) && !FLUSH;
        RES_DATA      = res_data_q;
        RES_RD        = rd_q;
        DIV_RS1       = rs1_q;
        DIV_RS2       = rs2_q;
        DIV_INST_DIV  = pulse && (op_q == DIV);
        DIV_INST_DIVU = pulse && (op_q == DIVU);
        DIV_INST_REM  = pulse && (op_q == REM);
        DIV_INST_REMU = pulse && (op_q == REMU);
    end

endmodule
